// File: rtl/frame_flip_sched.sv
// frame_flip_sched: sequences a double-buffered frame flip. It waits for the
// writer to finish the back frame and the reader to reach end of frame. It
// then quiesces both memory ports for GUARD cycles, flips, holds the ports
// quiet for GUARD more cycles, and finally acks the writer.
module frame_flip_sched #(
  parameter int unsigned GUARD = 4,   // 0..15 quiesce cycles on each side of the flip
  parameter int unsigned CNT_W = 16
) (
  input  logic             iClk,
  input  logic             iRst_,
  input  logic             iWrDone,
  input  logic             iRdEof,
  output logic             oFlip,
  output logic             oFace,
  output logic             oWrHold,
  output logic             oRdHold,
  output logic             oWrAck,
  output logic [CNT_W-1:0] oFrameCnt,
  output logic [7:0]       oDropCnt,
  output logic             oErr
);

  typedef enum logic [2:0] {
    IDLE, WAIT_EOF, GUARD_PRE, FLIP, GUARD_POST, ACK
  } state_e;

  // The guard counter counts down to zero, so it is loaded with GUARD-1.
  localparam logic [3:0] GLOAD = 4'((GUARD == 0) ? 0 : GUARD - 1);

  state_e           state_q, state_d;
  logic [3:0]       guard_q, guard_d;
  logic             face_q, flip_q, wr_hold_q, rd_hold_q, wr_ack_q, err_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [7:0]       drop_q;

  // Next-state and guard-counter logic; with GUARD=0 both guard states are bypassed.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    case (state_q)
      IDLE: begin
        if (iWrDone) begin
          if (iRdEof) begin
            if (GUARD == 0) state_d = FLIP;
            else begin
              state_d = GUARD_PRE;
              guard_d = GLOAD;
            end
          end else begin
            state_d = WAIT_EOF;
          end
        end
      end
      WAIT_EOF: begin
        if (iRdEof) begin
          if (GUARD == 0) state_d = FLIP;
          else begin
            state_d = GUARD_PRE;
            guard_d = GLOAD;
          end
        end
      end
      GUARD_PRE: begin
        if (guard_q == 4'd0) state_d = FLIP;
        else                 guard_d = guard_q - 4'd1;
      end
      FLIP: begin
        if (GUARD == 0) state_d = ACK;
        else begin
          state_d = GUARD_POST;
          guard_d = GLOAD;
        end
      end
      GUARD_POST: begin
        if (guard_q == 4'd0) state_d = ACK;
        else                 guard_d = guard_q - 4'd1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register. The strobes and holds are decoded from the next state so
  // every output comes straight from a flop.
  always_ff @(posedge iClk or negedge iRst_) begin
    if (!iRst_) begin
      state_q     <= IDLE;
      guard_q     <= 4'd0;
      face_q      <= 1'b1;
      flip_q      <= 1'b0;
      wr_hold_q   <= 1'b0;
      rd_hold_q   <= 1'b0;
      wr_ack_q    <= 1'b0;
      frame_cnt_q <= '0;
      drop_q      <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      flip_q    <= (state_d == FLIP);
      wr_ack_q  <= (state_d == ACK);
      wr_hold_q <= (state_d inside {WAIT_EOF, GUARD_PRE, FLIP, GUARD_POST});
      rd_hold_q <= (state_d inside {GUARD_PRE, FLIP, GUARD_POST});
      // Ownership and count change on the edge leaving FLIP.
      if (state_q == FLIP) begin
        face_q      <= ~face_q;
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
      // An EOF with no new frame ready means the reader repeats a frame.
      if (state_q == IDLE && iRdEof && !iWrDone && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
      // The writer must not report done again before it has been acked.
      if (iWrDone && state_q != IDLE)
        err_q <= 1'b1;
    end
  end

  assign oFlip     = flip_q;
  assign oFace     = face_q;
  assign oWrHold   = wr_hold_q;
  assign oRdHold   = rd_hold_q;
  assign oWrAck    = wr_ack_q;
  assign oFrameCnt = frame_cnt_q;
  assign oDropCnt  = drop_q;
  assign oErr      = err_q;

endmodule
